serial_subtractor: RTL and testbench

- Multi-cycle, digit-serial subtractor; the inverse-direction companion to the hybrid adders in the Adder Design set.
- Computes diff = a - b - bw_in over WIDTH/DIGIT clock cycles and retires DIGIT bits per cycle through a borrow-chained datapath.
- Uses a start/busy/done handshake so a controller or bench can issue back-to-back operations.

---
 rtl/serial_subtractor.sv | 155 +++++++++++++++
 tb/tb_serial_subtractor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial a - b - bw_in.
// One DIGIT-wide slice is retired per clock through a registered borrow chain.
// The public outputs (diff, bw_out, ovf) are written only when the last digit
// retires, so partial results never appear on them. start/busy/done handshake
// supports back-to-back operation with one op every N+1 cycles.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bw_in,
  output logic [WIDTH-1:0] diff,
  output logic             bw_out,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bw_out_q, bw_out_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operands viewed as digit arrays; shadow holds the partial result per digit.
  logic [DIGIT-1:0] a_dig    [N];
  logic [DIGIT-1:0] b_dig    [N];
  logic [DIGIT-1:0] shadow_q [N];
  logic [DIGIT-1:0] shadow_d [N];
  logic [WIDTH-1:0] shadow_flat;
  logic [DIGIT:0]   dig_sum;
  logic             dig_bw;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dig
      assign a_dig[gi] = a_q[gi*DIGIT +: DIGIT];
      assign b_dig[gi] = b_q[gi*DIGIT +: DIGIT];
      // Flattened next-shadow: on the final digit edge this already includes
      // the digit being retired, so it is the complete result.
      assign shadow_flat[gi*DIGIT +: DIGIT] = shadow_d[gi];
    end
  endgenerate

  // Digit datapath: one DIGIT-wide subtract with borrow; top bit is borrow-out.
  always_comb begin
    dig_sum  = {1'b0, a_dig[cnt_q]} - {1'b0, b_dig[cnt_q]} - {{DIGIT{1'b0}}, borrow_q};
    dig_bw   = dig_sum[DIGIT];
    shadow_d = shadow_q;
    if (state_q == S_RUN) begin
      shadow_d[cnt_q] = dig_sum[DIGIT-1:0];
    end
  end

  // Control: next-state, operand capture and result publication.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bw_out_d = bw_out_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          a_d      = a;
          b_d      = b;
          borrow_d = bw_in;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        borrow_d = dig_bw;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_DIGIT) begin
          state_d  = S_DONE;
          diff_d   = shadow_flat;
          bw_out_d = dig_bw;
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                     (shadow_flat[WIDTH-1] != a_q[WIDTH-1]);
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bw_out_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bw_out_q <= bw_out_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
    end
  end

  assign diff   = diff_q;
  assign bw_out = bw_out_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random operations checked against an
// arithmetic reference model (integer subtraction, range test for borrow).
module tb_serial_subtractor;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         bw_in = 1'b0;
  logic [W-1:0] diff;
  logic         bw_out;
  logic         ovf;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Expected values of the most recent completed operation.
  logic [W-1:0] exp_diff = '0;
  logic         exp_bw   = 1'b0;
  logic         exp_ovf  = 1'b0;

  serial_subtractor #(.WIDTH(W), .DIGIT(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a_in),
    .b      (b_in),
    .bw_in  (bw_in),
    .diff   (diff),
    .bw_out (bw_out),
    .ovf    (ovf),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, wrap modulo 2^W.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bw,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int r;
    r  = int'(a) - int'(b) - int'(bw);
    d  = W'(r);
    bo = (r < 0);
    ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endtask

  // One operation: launch, optionally hammer start/operands while busy, check.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bw,
                        input bit noisy);
    int n;
    int busy_cnt;
    logic [W-1:0] ed;
    logic eb, eo;
    model(a, b, bw, ed, eb, eo);
    @(negedge clk);
    a_in = a; b_in = b; bw_in = bw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    check_val("busy_after_start", busy, 1);
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      check_val("diff_stable", diff, exp_diff);
      if (noisy) begin
        start = 1'b1;
        a_in  = (n == 0) ? 8'hAA : W'($urandom);
        b_in  = (n == 0) ? 8'h55 : W'($urandom);
        bw_in = 1'($urandom);
      end else begin
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        bw_in = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_val("latency", n, N);
    check_val("busy_cycles", busy_cnt, N);
    check_val("done_pulse", done, 1);
    check_val("busy_at_done", busy, 0);
    check_val("diff", diff, ed);
    check_val("bw_out", bw_out, eb);
    check_val("ovf", ovf, eo);
    exp_diff = ed; exp_bw = eb; exp_ovf = eo;
    $display("op a=%02h b=%02h bw_in=%0d noisy=%0d -> diff=%02h bw_out=%0d ovf=%0d (exp %02h %0d %0d) lat=%0d",
             a, b, bw, noisy, diff, bw_out, ovf, ed, eb, eo, n);
    @(negedge clk);
    check_val("done_one_cycle", done, 0);
  endtask

  // Wait (bounded) for done with start held; returns cycle stamp.
  task automatic wait_done(output int stamp);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("b2b_done_seen", done, 1);
    stamp = cyc;
  endtask

  initial begin
    int t1, t2, extra_done;

    // Reset state
    #1;
    check_val("rst_diff", diff, 0);
    check_val("rst_bw_out", bw_out, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed test-plan operations
    run_op(8'h05, 8'h06, 1'b1, 1'b0);
    run_op(8'h33, 8'h36, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b0, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0);
    // start held and operands churned while busy: must not disturb the op
    run_op(8'h10, 8'h01, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check_val("no_extra_done", done, 0);
      check_val("idle_after_noisy", busy, 0);
    end

    // Back-to-back with start held high throughout
    @(negedge clk);
    a_in = 8'h20; b_in = 8'h10; bw_in = 1'b0; start = 1'b1;
    @(negedge clk);
    a_in = 8'hC3; b_in = 8'h3C;
    wait_done(t1);
    check_val("b2b_diff1", diff, 8'h10);
    check_val("b2b_bw1", bw_out, 0);
    a_in = 8'h01; b_in = 8'h02; bw_in = 1'b0;
    @(negedge clk);
    check_val("b2b_reaccept", busy, 1);
    check_val("b2b_done_low", done, 0);
    a_in = 8'h5A; b_in = 8'hA5;
    wait_done(t2);
    start = 1'b0;
    check_val("b2b_diff2", diff, 8'hFF);
    check_val("b2b_bw2", bw_out, 1);
    check_val("b2b_spacing", t2 - t1, N + 1);
    $display("op b2b: done at cycles %0d and %0d, diff=%02h bw_out=%0d", t1, t2, diff, bw_out);
    exp_diff = 8'hFF; exp_bw = 1'b1; exp_ovf = 1'b0;
    @(negedge clk);
    check_val("b2b_idle", busy, 0);

    // Leave nonzero outputs so the asynchronous clear is observable
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0);

    // Reset mid-RUN after two digit edges
    @(negedge clk);
    a_in = 8'h44; b_in = 8'h11; bw_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_diff", diff, 0);
    check_val("midrst_bw_out", bw_out, 0);
    check_val("midrst_ovf", ovf, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    $display("op mid-run reset: diff=%02h bw_out=%0d ovf=%0d busy=%0d", diff, bw_out, ovf, busy);
    @(negedge clk);
    rst = 1'b0;
    exp_diff = '0; exp_bw = 1'b0; exp_ovf = 1'b0;
    extra_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check_val("midrst_no_done", extra_done, 0);
    run_op(8'h09, 8'h03, 1'b0, 1'b0);

    // Random operations
    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
